// File: rtl/rom_dl_pkg.sv
// ============================================================================
// Module  : rom_dl_pkg
// Brief   : Shared types and sizing helpers for the ROM-download router.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package rom_dl_pkg;

  localparam int c_ADDR_W = 25;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_HOLD  = 2'd2,
    ST_READY = 2'd3
  } dl_state_e;

  function automatic int region_sel_w(input int nr);
    return (nr > 1) ? $clog2(nr) : 1;
  endfunction

  function automatic logic [c_ADDR_W-1:0] image_size(input int aw, input int nr);
    return c_ADDR_W'(nr * (2 ** aw));
  endfunction

endpackage

`default_nettype wire

// File: rtl/dl_region_dec.sv
// ============================================================================
// Module  : dl_region_dec
// Brief   : Decodes an image byte address into range-ok and one-hot region enable.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module dl_region_dec
  import rom_dl_pkg::*;
#(
  parameter int AW = 14,
  parameter int NR = 4
) (
  input  logic [c_ADDR_W-1:0] dl_ad_i,
  output logic                range_ok_o,
  output logic [NR-1:0]       region_we_o
);

  localparam int c_SEL_W = region_sel_w(NR);
  localparam int c_TOP   = AW + $clog2(NR);

  // NR is a power of two, so the image ends exactly at bit c_TOP
  assign range_ok_o = ((dl_ad_i >> c_TOP) == '0);

  generate
    if (NR == 1) begin : g_single
      assign region_we_o = 1'b1;
    end else begin : g_multi
      logic [c_SEL_W-1:0] w_sel;
      assign w_sel       = dl_ad_i[c_TOP-1:AW];
      assign region_we_o = NR'(1) << w_sel;
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/rom_dl_router.sv
// ============================================================================
// Module  : rom_dl_router
// Brief   : Routes the HPS download stream to ROM write ports, checks the image
//           and holds the CPU in reset until a complete valid image is loaded.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module rom_dl_router
  import rom_dl_pkg::*;
#(
  parameter int          AW   = 14,
  parameter int          NR   = 4,
  parameter int unsigned IDX  = 0,
  parameter int unsigned HOLD = 16
) (
  input  logic                cl_i,
  input  logic                rst_n_i,
  input  logic                dl_act_i,
  input  logic [7:0]          dl_idx_i,
  input  logic                dl_wr_i,
  input  logic [c_ADDR_W-1:0] dl_ad_i,
  input  logic [7:0]          dl_dt_i,
  output logic [AW-1:0]       rom_ad_o,
  output logic [7:0]          rom_di_o,
  output logic [NR-1:0]       rom_we_o,
  output logic                cpu_rst_o,
  output logic                dl_done_o,
  output logic                dl_err_o,
  output logic [7:0]          dl_sum_o
);

  localparam logic [c_ADDR_W-1:0] c_IMG      = image_size(AW, NR);
  localparam int                  c_CNT_W    = $clog2(HOLD + 1);
  localparam logic [c_CNT_W-1:0]  c_CNT_LOAD = c_CNT_W'(HOLD - 1);
  localparam logic [7:0]          c_IDX      = 8'(IDX);

  dl_state_e             state_q, state_d;
  logic [c_CNT_W-1:0]    cnt_q, cnt_d;
  logic [c_ADDR_W-1:0]   exp_q, exp_d;
  logic [7:0]            sum_q, sum_d;
  logic                  err_q, err_d;
  logic [NR-1:0]         we_q, we_d;
  logic [AW-1:0]         ad_q, ad_d;
  logic [7:0]            di_q, di_d;

  logic                  w_match, w_start, w_accept, w_range_ok;
  logic [NR-1:0]         w_region_we;

  dl_region_dec #(.AW(AW), .NR(NR)) u_dec (
    .dl_ad_i     (dl_ad_i),
    .range_ok_o  (w_range_ok),
    .region_we_o (w_region_we)
  );

  assign w_match  = dl_act_i && (dl_idx_i == c_IDX);
  assign w_start  = w_match && (state_q != ST_LOAD);
  assign w_accept = dl_wr_i && w_match && (state_q != ST_HOLD);

  always_ff @(posedge cl_i or negedge rst_n_i) begin
    if (!rst_n_i) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_READY: if (w_match) state_d = ST_LOAD;
      ST_LOAD:           if (!w_match) state_d = ST_HOLD;
      ST_HOLD: begin
        if (w_match)             state_d = ST_LOAD;
        else if (cnt_q == '0)    state_d = ST_READY;
      end
      default:           state_d = ST_IDLE;
    endcase
  end

  // A new download clears the checks first; a byte in the entry cycle then builds on that
  always_comb begin
    sum_d = w_start ? 8'd0 : sum_q;
    err_d = w_start ? 1'b0 : err_q;
    exp_d = w_start ? '0   : exp_q;
    cnt_d = cnt_q;
    we_d  = '0;
    ad_d  = ad_q;
    di_d  = di_q;
    if (w_accept) begin
      if (!w_range_ok) begin
        err_d = 1'b1;
      end else begin
        we_d  = w_region_we;
        ad_d  = dl_ad_i[AW-1:0];
        di_d  = dl_dt_i;
        sum_d = sum_d + dl_dt_i;
        if (dl_ad_i != exp_d) err_d = 1'b1;
        exp_d = dl_ad_i + c_ADDR_W'(1);
      end
    end
    if (state_q == ST_LOAD && !w_match) begin
      cnt_d = c_CNT_LOAD;
      if (exp_q != c_IMG) err_d = 1'b1;
    end
    if (state_q == ST_HOLD && !w_match && cnt_q != '0) cnt_d = cnt_q - c_CNT_W'(1);
  end

  always_ff @(posedge cl_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
      exp_q <= '0;
      sum_q <= '0;
      err_q <= 1'b0;
      we_q  <= '0;
      ad_q  <= '0;
      di_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      exp_q <= exp_d;
      sum_q <= sum_d;
      err_q <= err_d;
      we_q  <= we_d;
      ad_q  <= ad_d;
      di_q  <= di_d;
    end
  end

  assign rom_we_o  = we_q;
  assign rom_ad_o  = ad_q;
  assign rom_di_o  = di_q;
  assign dl_sum_o  = sum_q;
  assign dl_err_o  = err_q;
  assign dl_done_o = (state_q == ST_READY) && !err_q;
  assign cpu_rst_o = !dl_done_o;

endmodule

`default_nettype wire

// File: tb/tb_rom_dl_router.sv
// ============================================================================
// Module  : tb_rom_dl_router
// Brief   : Scoreboard bench for rom_dl_router (AW=4, NR=2, IDX=0, HOLD=16).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rom_dl_router;

  localparam int AW   = 4;
  localparam int NR   = 2;
  localparam int HOLD = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        dl_act;
  logic [7:0]  dl_idx;
  logic        dl_wr;
  logic [24:0] dl_ad;
  logic [7:0]  dl_dt;
  logic [AW-1:0] rom_ad;
  logic [7:0]  rom_di;
  logic [NR-1:0] rom_we;
  logic        cpu_rst, dl_done, dl_err;
  logic [7:0]  dl_sum;

  always #5 clk = ~clk;

  rom_dl_router #(.AW(AW), .NR(NR), .IDX(0), .HOLD(HOLD)) dut (
    .cl_i      (clk),
    .rst_n_i   (rst_n),
    .dl_act_i  (dl_act),
    .dl_idx_i  (dl_idx),
    .dl_wr_i   (dl_wr),
    .dl_ad_i   (dl_ad),
    .dl_dt_i   (dl_dt),
    .rom_ad_o  (rom_ad),
    .rom_di_o  (rom_di),
    .rom_we_o  (rom_we),
    .cpu_rst_o (cpu_rst),
    .dl_done_o (dl_done),
    .dl_err_o  (dl_err),
    .dl_sum_o  (dl_sum)
  );

  typedef struct {
    logic [NR-1:0] we;
    logic [AW-1:0] ad;
    logic [7:0]    di;
    int            cyc;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   we_pulses = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Every write pulse must match the oldest expected write, in the expected cycle
  always @(negedge clk) begin
    if (rom_we != '0) begin
      we_pulses++;
      n_cmp++;
      if (sbq.size() == 0) begin
        n_err++;
        $display("FAIL we_unexpected: got we=%b ad=%h di=%h cyc=%0d, required no write",
                 rom_we, rom_ad, rom_di, cyc);
      end else begin
        mon_e = sbq.pop_front();
        if (rom_we !== mon_e.we || rom_ad !== mon_e.ad || rom_di !== mon_e.di || cyc != mon_e.cyc) begin
          n_err++;
          $display("FAIL we_write: got we=%b ad=%h di=%h cyc=%0d, required we=%b ad=%h di=%h cyc=%0d",
                   rom_we, rom_ad, rom_di, cyc, mon_e.we, mon_e.ad, mon_e.di, mon_e.cyc);
        end
      end
    end else if (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
      n_cmp++;
      n_err++;
      mon_e = sbq.pop_front();
      $display("FAIL we_missing: got no write at cyc=%0d, required we=%b ad=%h di=%h",
               cyc, mon_e.we, mon_e.ad, mon_e.di);
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
    n_cmp++;
    if (got !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", name, got, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic act, input logic [7:0] idx, input logic wr,
                       input logic [24:0] ad, input logic [7:0] dt);
    exp_t e;
    tick();
    dl_act = act;
    dl_idx = idx;
    dl_wr  = wr;
    dl_ad  = ad;
    dl_dt  = dt;
    if (act && wr && idx == 8'd0 && ad < 25'd32) begin
      e.we  = NR'(1) << ad[AW];
      e.ad  = ad[AW-1:0];
      e.di  = dt;
      e.cyc = cyc + 1;
      sbq.push_back(e);
    end
  endtask

  task automatic load_range(input int lo, input int hi, input int skip, input bit gaps);
    for (int a = lo; a <= hi; a++) begin
      if (a != skip) begin
        drive(1'b1, 8'd0, 1'b1, 25'(a), 8'(a));
        if (gaps) drive(1'b1, 8'd0, 1'b0, 25'd0, 8'd0);
      end
    end
  endtask

  task automatic end_dl();
    drive(1'b0, 8'd0, 1'b0, 25'd0, 8'd0);
  endtask

  // Cycles from the first DL_ACT=0 cycle until CPU_RST is seen low; -1 on timeout
  task automatic wait_release(output int delta);
    int start;
    start = cyc;
    delta = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!cpu_rst) begin
        delta = cyc - start;
        break;
      end
    end
  endtask

  int d;
  int p0;

  initial begin
    rst_n = 1'b0; dl_act = 1'b0; dl_idx = 8'd0; dl_wr = 1'b0; dl_ad = '0; dl_dt = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_we", rom_we, 0);
    chk("rst_ad", rom_ad, 0);
    chk("rst_di", rom_di, 0);
    chk("rst_cpu_rst", cpu_rst, 1);
    chk("rst_done", dl_done, 0);
    chk("rst_err", dl_err, 0);
    chk("rst_sum", dl_sum, 0);
    rst_n = 1'b1;

    // Clean image with idle gaps; first byte arrives in the entry cycle
    load_range(0, 31, -1, 1'b1);
    chk("img_sum", dl_sum, 8'hF0);
    chk("img_err", dl_err, 0);
    end_dl();
    wait_release(d);
    chk("img_release_delay", d, 17);
    chk("img_done", dl_done, 1);

    // Re-download from READY, address 5 skipped
    drive(1'b1, 8'd0, 1'b0, 25'd0, 8'd0);
    tick();
    chk("redl_cpu_rst", cpu_rst, 1);
    chk("redl_done", dl_done, 0);
    load_range(0, 31, 5, 1'b1);
    chk("skip_sum", dl_sum, 8'hEB);
    chk("skip_err", dl_err, 1);
    end_dl();
    repeat (30) @(negedge clk);
    chk("skip_cpu_rst", cpu_rst, 1);
    chk("skip_done", dl_done, 0);

    // Out-of-range byte mid-image
    drive(1'b1, 8'd0, 1'b0, 25'd0, 8'd0);
    load_range(0, 15, -1, 1'b1);
    chk("oor_sum_before", dl_sum, 8'h78);
    chk("oor_err_before", dl_err, 0);
    drive(1'b1, 8'd0, 1'b1, 25'h20, 8'hAA);
    drive(1'b1, 8'd0, 1'b0, 25'd0, 8'd0);
    chk("oor_sum", dl_sum, 8'h78);
    chk("oor_err", dl_err, 1);
    load_range(16, 31, -1, 1'b1);
    chk("oor_sum_final", dl_sum, 8'hF0);
    end_dl();
    repeat (30) @(negedge clk);
    chk("oor_cpu_rst", cpu_rst, 1);
    chk("oor_done", dl_done, 0);

    // Back-to-back strobes
    drive(1'b1, 8'd0, 1'b0, 25'd0, 8'd0);
    p0 = we_pulses;
    load_range(0, 31, -1, 1'b0);
    end_dl();
    wait_release(d);
    chk("b2b_pulses", we_pulses - p0, 32);
    chk("b2b_release_delay", d, 17);
    chk("b2b_done", dl_done, 1);
    chk("b2b_sum", dl_sum, 8'hF0);

    // Foreign download index while READY
    drive(1'b1, 8'd3, 1'b0, 25'd0, 8'd0);
    for (int a = 0; a < 4; a++) drive(1'b1, 8'd3, 1'b1, 25'(a), 8'h55);
    end_dl();
    repeat (5) @(negedge clk);
    chk("idx3_cpu_rst", cpu_rst, 0);
    chk("idx3_done", dl_done, 1);
    chk("idx3_sum", dl_sum, 8'hF0);

    // Re-download, then asynchronous reset at byte 10
    drive(1'b1, 8'd0, 1'b0, 25'd0, 8'd0);
    tick();
    chk("redl2_cpu_rst", cpu_rst, 1);
    load_range(0, 9, -1, 1'b1);
    chk("pre_rst_sum", dl_sum, 8'd45);
    tick();
    dl_wr = 1'b1; dl_ad = 25'd10; dl_dt = 8'd10;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_we", rom_we, 0);
    chk("arst_cpu_rst", cpu_rst, 1);
    chk("arst_sum", dl_sum, 0);
    dl_wr = 1'b0; dl_act = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    load_range(0, 31, -1, 1'b1);
    chk("reload_err", dl_err, 0);
    end_dl();
    wait_release(d);
    chk("reload_release_delay", d, 17);
    chk("reload_done", dl_done, 1);
    chk("reload_sum", dl_sum, 8'hF0);

    repeat (3) @(negedge clk);
    chk("sb_drained", sbq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/rom_dl_router.md
# rom_dl_router

Routes the HPS ROM-download byte stream into the core's download-ROM write ports (clock/address/data/write-enable per ROM region) and owns the CPU reset during loading. Sits directly upstream of every download ROM instance, on the same clock as their load ports. Checks address contiguity and image size, keeps a running checksum, and releases the CPU only after a complete image plus a hold interval.

## Interface
- AW, 14, address width of one ROM region (region = 2**AW bytes)
- NR, 4, number of regions; power of two, 1..8; image size = NR*2**AW
- IDX, 0, download index accepted; other indices ignored
- HOLD, 16, cycles CPU_RST stays high after download end (≥1)

- CL  in  1  clock, shared with the ROM load ports
- RST_N  in  1  reset, asynchronous, active-low
- DL_ACT  in  1  download active (level)
- DL_IDX  in  8  download index
- DL_WR  in  1  one-cycle byte strobe
- DL_AD  in  25  byte address in image
- DL_DT  in  8  byte data
- ROM_AD  out  AW  region-local write address
- ROM_DI  out  8  write data
- ROM_WE  out  NR  one-hot write enable, bit n = region n
- CPU_RST  out  1  active-high CPU reset
- DL_DONE  out  1  image complete and valid, CPU running
- DL_ERR  out  1  sticky error for current download
- DL_SUM  out  8  modulo-256 sum of accepted bytes

## Operation
- Accepted byte: DL_WR & DL_ACT & (DL_IDX==IDX) while in IDLE or LOAD. All other strobes ignored entirely (no WE, no sum, no error).
- States: IDLE, LOAD, HOLD, READY.
- Reset: IDLE; CPU_RST=1; ROM_WE=0; ROM_AD=0; ROM_DI=0; DL_DONE=0; DL_ERR=0; DL_SUM=0; expected address EXP=0.
- IDLE/READY → LOAD when DL_ACT & DL_IDX==IDX: clear DL_SUM, DL_ERR, EXP, DL_DONE; CPU_RST=1. A byte accepted in the entry cycle is processed as a LOAD byte (sum starts from it).
- LOAD, accepted byte:
  - DL_AD ≥ NR*2**AW → DL_ERR=1, no write, sum unchanged, EXP unchanged.
  - else: ROM_WE[DL_AD[AW+2:AW] truncated to log2(NR) bits]=1, ROM_AD=DL_AD[AW-1:0], ROM_DI=DL_DT; DL_SUM+=DL_DT (wraps); if DL_AD≠EXP → DL_ERR=1 (write still performed); EXP=DL_AD+1.
- LOAD → HOLD when DL_ACT=0 (or DL_IDX≠IDX while active). If EXP≠NR*2**AW at that point → DL_ERR=1. Hold counter loaded with HOLD-1.
- HOLD: counter decrements each cycle; at 0 → READY. A new matching DL_ACT during HOLD → LOAD (counter abandoned).
- READY: CPU_RST=0; DL_DONE=~DL_ERR. With DL_ERR=1, READY still releases nothing: CPU_RST stays 1, DL_DONE=0.
- Non-matching downloads in READY leave CPU_RST/DL_DONE untouched.

## Timing
- ROM_WE/ROM_AD/ROM_DI registered: WE high exactly the cycle after the accepted strobe, one cycle wide; AD/DI hold until next accepted byte.
- Back-to-back strobes (every cycle) supported: one WE pulse per byte, no drops.
- DL_SUM/DL_ERR update same edge as ROM_WE.
- Download end: byte with DL_WR in the same cycle DL_ACT falls is not accepted (DL_ACT gates it).
- CPU_RST falls HOLD cycles after the first cycle with DL_ACT=0 (LOAD→HOLD edge + HOLD); DL_DONE rises same edge.
- Re-download from READY: CPU_RST rises and DL_DONE falls on the edge after DL_ACT rises.
- RST_N assertion mid-LOAD: all outputs to reset values immediately (asynchronous); ROM_WE cleared, partial image remains in ROMs; next download restarts at EXP=0.

## Structure
- Package rom_dl_pkg: state enum (IDLE, LOAD, HOLD, READY), image-size and region-select-width constants derived from AW/NR.
- One sub-module natural: dl_region_dec (DL_AD → range-ok flag + one-hot region enable, combinational), reused by other cores' routers.
- Hold counter width clog2(HOLD+1); EXP width 25 bits.

## Test plan
- AW=4, NR=2: 32 contiguous bytes 0x00..0x1F, data=addr → ROM_WE[0] for 0..15, ROM_WE[1] for 16..31, ROM_AD=addr&0xF, DL_SUM=0xF0, DL_ERR=0, CPU_RST falls 16 cycles after DL_ACT drop, DL_DONE=1.
- Same image, skip address 5 → write of 6 still occurs, DL_ERR=1, CPU_RST stays 1, DL_DONE=0.
- Address 0x20 strobed mid-image → no ROM_WE, DL_ERR=1, DL_SUM unchanged.
- Download with DL_IDX=3 during READY → no ROM_WE, CPU_RST=0 and DL_DONE=1 unchanged.
- Strobes every cycle, 32 bytes → exactly 32 WE pulses, each one cycle after its strobe; then re-download → CPU_RST=1 next cycle.
- RST_N low at byte 10 → ROM_WE=0, CPU_RST=1, DL_SUM=0 immediately; full reload afterwards completes with DL_DONE=1.
